// File: rtl/uart_msg_pkg.sv
// Shared types and ASCII helpers for the UART message checker.
package uart_msg_pkg;

  typedef enum logic [1:0] {
    HUNT,
    MATCH,
    SKIP,
    REPORT
  } state_t;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // Folds a-z onto A-Z; every other byte passes through unchanged.
  function automatic logic [7:0] to_upper(input logic [7:0] b);
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
    return b;
  endfunction

endpackage

// File: rtl/uart_msg_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_MAX = '1;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && q != Q_MAX) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_msg_checker.sv
// Line checker behind uart_rx: compares each TERM-terminated line with MSG and counts verdicts.
// Optional build macro UART_MSG_CHECKER_CASE_EN enables case-insensitive letter comparison.
module uart_msg_checker
  import uart_msg_pkg::*;
#(
  parameter int                   MSG_LEN = 13,
  parameter logic [MSG_LEN*8-1:0] MSG     = "Hello world!\n",
  parameter logic [7:0]           TERM    = ASCII_LF,
  parameter int                   CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_tvalid,
  output logic             i_tready,
  input  logic [7:0]       i_tdata,
  input  logic             i_clear,
  output logic             o_match_pulse,
  output logic             o_err_pulse,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [7:0]       o_last_byte
);

  localparam int               IDX_W    = $clog2(MSG_LEN);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             ok_q, ok_d;
  logic             run_q;
  logic             accept;
  logic             is_term;
  logic             cmp;
  logic [7:0]       exp_byte;

  // run_q holds ready low while in reset and for the edge that releases it.
  assign i_tready = run_q && (state_q != REPORT);
  assign accept   = i_tvalid && i_tready;
  assign exp_byte = MSG[8*(MSG_LEN-1-int'(idx_q)) +: 8];
  assign is_term  = (i_tdata == TERM);

`ifdef UART_MSG_CHECKER_CASE_EN
  assign cmp = (to_upper(i_tdata) == to_upper(exp_byte));
`else
  assign cmp = (i_tdata == exp_byte);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= HUNT;
      idx_q       <= '0;
      ok_q        <= 1'b0;
      run_q       <= 1'b0;
      o_last_byte <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ok_q    <= ok_d;
      run_q   <= 1'b1;
      if (accept) o_last_byte <= i_tdata;
    end
  end

  // NOTE: every output of this block is assigned a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ok_d    = ok_q;
    unique case (state_q)
      HUNT: begin
        if (accept && !is_term) begin
          if (cmp) begin
            idx_d   = IDX_W'(1);
            state_d = MATCH;
          end else begin
            state_d = SKIP;
          end
        end
      end
      MATCH: begin
        if (accept) begin
          if (cmp && idx_q == IDX_LAST) begin
            ok_d    = 1'b1;
            state_d = REPORT;
          end else if (cmp) begin
            idx_d = idx_q + 1'b1;
          end else if (is_term) begin
            ok_d    = 1'b0;
            state_d = REPORT;
          end else begin
            state_d = SKIP;
          end
        end
      end
      SKIP: begin
        if (accept && is_term) begin
          ok_d    = 1'b0;
          state_d = REPORT;
        end
      end
      REPORT: begin
        idx_d   = '0;
        state_d = HUNT;
      end
      default: begin
        idx_d   = '0;
        state_d = HUNT;
      end
    endcase
  end

  assign o_match_pulse = (state_q == REPORT) && ok_q;
  assign o_err_pulse   = (state_q == REPORT) && !ok_q;

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (i_clear),
    .inc  (o_match_pulse),
    .q    (o_match_cnt)
  );

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk  (clk),
    .rstn (rstn),
    .clr  (i_clear),
    .inc  (o_err_pulse),
    .q    (o_err_cnt)
  );

endmodule

// File: tb/tb_uart_msg_checker.sv
// Self-checking bench for uart_msg_checker: line-level reference model plus directed line vectors.
module tb_uart_msg_checker;

  localparam int         CNT_W = 4;
  localparam int         C_MAX = (1 << CNT_W) - 1;
  localparam logic [7:0] LF    = 8'h0A;

  logic             clk = 1'b0;
  logic             rstn;
  logic             i_tvalid;
  logic             i_tready;
  logic [7:0]       i_tdata;
  logic             i_clear;
  logic             o_match_pulse;
  logic             o_err_pulse;
  logic [CNT_W-1:0] o_match_cnt;
  logic [CNT_W-1:0] o_err_cnt;
  logic [7:0]       o_last_byte;

  int total = 0;
  int bad   = 0;
  int obs_match = 0;
  int obs_err   = 0;

  uart_msg_checker #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_tvalid      (i_tvalid),
    .i_tready      (i_tready),
    .i_tdata       (i_tdata),
    .i_clear       (i_clear),
    .o_match_pulse (o_match_pulse),
    .o_err_pulse   (o_err_pulse),
    .o_match_cnt   (o_match_cnt),
    .o_err_cnt     (o_err_cnt),
    .o_last_byte   (o_last_byte)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: whole-line verdicts ----------------
  string      exp_line = "Hello world!";
  logic [7:0] line_q[$];
  bit         m_run;
  int         m_rep;          // 0 none, 1 match pending, 2 error pending
  int         m_match, m_err;
  logic [7:0] m_last;

  function automatic logic [7:0] fold(input logic [7:0] b);
`ifdef UART_MSG_CHECKER_CASE_EN
    if (b inside {[8'h61:8'h7A]}) return b ^ 8'h20;
`endif
    return b;
  endfunction

  function automatic bit line_ok();
    if (line_q.size() != exp_line.len()) return 1'b0;
    for (int i = 0; i < exp_line.len(); i++)
      if (fold(line_q[i]) != fold(exp_line[i])) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (!rstn) begin
      check("rst_tready", i_tready, 0);
      check("rst_pulses", {o_match_pulse, o_err_pulse}, 0);
      check("rst_cnts", {o_match_cnt, o_err_cnt}, 0);
      check("rst_last", o_last_byte, 0);
      line_q.delete();
      m_run = 0; m_rep = 0; m_match = 0; m_err = 0; m_last = 0;
    end else begin
      check("tready", i_tready, m_run && m_rep == 0);
      check("match_pulse", o_match_pulse, m_rep == 1);
      check("err_pulse", o_err_pulse, m_rep == 2);
      check("match_cnt", o_match_cnt, m_match);
      check("err_cnt", o_err_cnt, m_err);
      check("last_byte", o_last_byte, m_last);
      if (o_match_pulse) obs_match++;
      if (o_err_pulse) obs_err++;
      // predict the state after the coming rising edge
      if (i_clear) begin
        m_match = 0;
        m_err   = 0;
      end else begin
        if (m_rep == 1 && m_match < C_MAX) m_match++;
        if (m_rep == 2 && m_err < C_MAX) m_err++;
      end
      if (i_tvalid && m_run && m_rep == 0) begin
        m_last = i_tdata;
        m_rep  = 0;
        if (i_tdata == LF) begin
          if (line_q.size() > 0) m_rep = line_ok() ? 1 : 2;
          line_q.delete();
        end else begin
          line_q.push_back(i_tdata);
        end
      end else begin
        m_rep = 0;
      end
      m_run = 1;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input logic [7:0] b);
    bit acc = 0;
    int n = 0;
    i_tvalid = 1'b1;
    i_tdata  = b;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = i_tready;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_in_budget", acc, 1);
  endtask

  task automatic send_line(input string s, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    if (gap > 0) begin
      i_tvalid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    i_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    i_clear = 1'b1;
    @(posedge clk);
    #1;
    i_clear   = 1'b0;
    obs_match = 0;
    obs_err   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0; i_tvalid = 1'b0; i_tdata = 8'h00; i_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(2);
    check("ready_after_reset", i_tready, 1);

    // 1: three good lines
    clear_all();
    for (int k = 0; k < 3; k++) send_line("Hello world!\n", 3);
    check("t1_match_cnt", o_match_cnt, 3);
    check("t1_err_cnt", o_err_cnt, 0);
    check("t1_match_pulses", obs_match, 3);

    // 2: wrong char then a good line
    clear_all();
    send_line("Hello_world!\n", 3);
    check("t2_err_cnt", o_err_cnt, 1);
    send_line("Hello world!\n", 3);
    check("t2_match_cnt", o_match_cnt, 1);

    // 3: short, empty, long
    clear_all();
    send_line("Hello\n", 3);
    send_line("\n", 3);
    check("t3_empty_no_pulse", obs_err + obs_match, 1);
    send_line("Hello world!!\n", 3);
    check("t3_err_cnt", o_err_cnt, 2);
    check("t3_match_cnt", o_match_cnt, 0);

    // 4: back-to-back, valid held high
    clear_all();
    for (int k = 0; k < 3; k++) begin
      send_line("Hello world!\n", 0);
      check("t4_last_byte", o_last_byte, 8'h0A);
    end
    idle(3);
    check("t4_match_cnt", o_match_cnt, 3);

    // 5: saturation, then clear colliding with REPORT
    clear_all();
    for (int k = 0; k < 17; k++) send_line("Hello world!\n", 1);
    idle(2);
    check("t5_sat", o_match_cnt, 15);
    check("t5_pulses", obs_match, 17);
    send_line("Hello world!\n", 0);
    i_tvalid = 1'b0;
    i_clear  = 1'b1;
    @(posedge clk);
    #1;
    i_clear = 1'b0;
    idle(2);
    check("t5_clear_wins", o_match_cnt, 0);

    // 6: upper-case line, then reset mid-line
    clear_all();
    send_line("HELLO WORLD!\n", 3);
`ifdef UART_MSG_CHECKER_CASE_EN
    check("t6_case_match", o_match_cnt, 1);
    check("t6_case_err", o_err_cnt, 0);
`else
    check("t6_case_match", o_match_cnt, 0);
    check("t6_case_err", o_err_cnt, 1);
`endif
    obs_match = 0;
    obs_err   = 0;
    send_line("Hel", 0);
    i_tvalid = 1'b0;
    rstn     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    idle(3);
    check("t6_no_pulse_after_rst", obs_match + obs_err, 0);
    send_line("Hello world!\n", 3);
    check("t6_match_after_rst", o_match_cnt, 1);
    check("t6_err_after_rst", o_err_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
